slave_port: RTL and testbench
=============================

// Module: slave_port
// PURPOSE
//  Responder end of the serial system bus; mirror of the bus-side interface of the initiator port.
//  Receives a 16-bit address MSB-first and decodes device select from addr[15:12].
//  Then either shifts in 8 write-data bits, or fetches a byte from a local memory and shifts it out.
//  Sits between the bus interconnect and one slave memory/peripheral.
// PARAMETERS
//  DEVICE_ID   4'h0  value of addr[15:12] this slave answers to
//  RD_LATENCY  1     cycles from s_rd_en to s_rd_data valid (1..4)
// PORTS
//  clk           in   1   system clock, all logic on posedge
//  rst           in   1   synchronous reset, active-high
//  mode          in   1   transfer type from master, 1=write 0=read; stable for whole transaction
//  wr_bus        in   1   serial addr/write-data bit from master, MSB first
//  master_valid  in   1   master presents a bit on wr_bus (address and write-data phases)
//  slave_ready   out  1   slave accepts wr_bus bit; bit transfers when master_valid & slave_ready
//  ack           out  1   device-select acknowledge, sampled by master at the 6th address beat
//  rd_bus        out  1   serial read-data bit to master, MSB first
//  slave_valid   out  1   rd_bus holds a valid bit; bit transfers when slave_valid & master_ready
//  master_ready  in   1   master accepts a read bit
//  s_addr        out  12  local address = received addr[11:0]; held until next transaction
//  s_wr_data     out  8   received write byte
//  s_wr_en       out  1   one-cycle write strobe to local memory
//  s_rd_en       out  1   one-cycle read strobe to local memory
//  s_rd_data     in   8   local read data, valid RD_LATENCY cycles after s_rd_en
// BEHAVIOUR
//  Reset
//  - All outputs 0 except slave_ready=1.
//  - State=IDLE, bit counter=0, shift regs=0.
//  - rst mid-transaction aborts with no memory strobe.
//  Beat rule
//  - Address/write beat = master_valid & slave_ready.
//  - Read beat = slave_valid & master_ready.
//  - One 4-bit counter counts beats per phase.
//  States
//  - IDLE: slave_ready=1.
//    - First beat shifts bit in, captures mode, cnt=1, goes to ADDR.
//  - ADDR: slave_ready=1; shift addr on each beat.
//    - Once 4 bits are held (cnt>=4), ack = (addr_sr[3:0]==DEVICE_ID), combinational from shift reg, so ack is valid on beats 5..16.
//    - No match: at the 6th beat go to SKIP.
//    - Match: at the 16th beat latch s_addr=addr[11:0], then go to WR_DATA (mode=1) or RD_REQ (mode=0).
//  - SKIP: ack=0, slave_ready=0.
//    - Return to IDLE when master_valid=0.
//    - No strobes are issued.
//  - WR_DATA: ack=1, slave_ready=1; shift wr_bus into data reg on each beat.
//    - On the 8th beat: s_wr_data=byte, s_wr_en=1 in the next cycle, go to IDLE.
//  - RD_REQ: ack=1, slave_ready=0, s_rd_en=1 for exactly one cycle, go to RD_WAIT.
//  - RD_WAIT: count RD_LATENCY cycles, load s_rd_data into the out shift reg, go to RD_DATA.
//  - RD_DATA: ack=1, slave_valid=1, rd_bus=sr[7].
//    - On each read beat: shift left, cnt+1.
//    - If master_ready=0, hold bit and slave_valid unchanged.
//    - On the 8th beat, go to IDLE; slave_valid drops the next cycle.
//  Boundaries and timing
//  - master_valid low for one cycle mid-ADDR/WR_DATA: hold, no beat, no timeout.
//  - The master has a 2-cycle gap between transactions; IDLE accepts a new first beat in the cycle after any return to IDLE.
//  - The bit counter wraps only via explicit clear on each phase change.
//  - Write-to-strobe latency: 1 cycle after the last write beat.
//  - Read: first slave_valid arrives RD_LATENCY+2 cycles after the 16th address beat.
// TESTING
//  1. Write 0x0A5C with data 0x3C, DEVICE_ID=0 -> s_wr_en single pulse, s_addr=0xA5C, s_wr_data=0x3C; ack high from beat 5.
//  2. Read addr 0x0123, memory returns 0xC5 -> one s_rd_en pulse, rd_bus serial 1,1,0,0,0,1,0,1, then IDLE.
//  3. Addr 0x7123 with DEVICE_ID=0 -> ack=0 at beat 6, SKIP, no s_wr_en or s_rd_en, IDLE after master_valid drops.
//  4. master_ready toggling 1/0 during read of 0x81 -> each bit held until its beat, exactly 8 beats, data intact.
//  5. rst asserted at write data beat 4 -> no s_wr_en; all outputs at reset values next cycle; next transaction completes correctly.
//  6. Back-to-back write then read, 2-cycle gap, RD_LATENCY=3 -> both complete; first read bit 5 cycles after the 16th address beat.

Source files
------------

// File: rtl/slave_port.sv
// -----------------------------------------------------------------------------
// slave_port
//   Responder end of the serial system bus. Receives a 16-bit address MSB
//   first, answers when addr[15:12] equals DEVICE_ID, then either shifts in
//   one write byte and strobes it into the local memory, or strobes a local
//   read and shifts the returned byte out MSB first.
//
// Ports
//   clk           system clock, all state on posedge
//   rst           synchronous reset, active-high
//   mode          transfer type from master (1 = write, 0 = read)
//   wr_bus        serial address / write-data bit from master
//   master_valid  master presents a bit on wr_bus
//   slave_ready   slave accepts the wr_bus bit this cycle
//   ack           device-select acknowledge (valid from address beat 5)
//   rd_bus        serial read-data bit to master
//   slave_valid   rd_bus holds a valid bit
//   master_ready  master accepts the rd_bus bit this cycle
//   s_addr        local address, addr[11:0] of the last matched transaction
//   s_wr_data     last received write byte
//   s_wr_en       one-cycle local write strobe
//   s_rd_en       one-cycle local read strobe
//   s_rd_data     local read data, valid RD_LATENCY cycles after s_rd_en
// -----------------------------------------------------------------------------
module slave_port #(
  parameter logic [3:0]  DEVICE_ID  = 4'h0,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        wr_bus,
  input  logic        master_valid,
  output logic        slave_ready,
  output logic        ack,
  output logic        rd_bus,
  output logic        slave_valid,
  input  logic        master_ready,
  output logic [11:0] s_addr,
  output logic [7:0]  s_wr_data,
  output logic        s_wr_en,
  output logic        s_rd_en,
  input  logic [7:0]  s_rd_data
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StSkip,
    StWrData,
    StRdReq,
    StRdWait,
    StRdData
  } state_e;

  // Last RD_WAIT count before the local read data is sampled.
  localparam logic [3:0] LatLast = 4'(RD_LATENCY - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        mode_q;
  // Only 11 address bits need to be kept: together with the 16th bit on
  // wr_bus they form s_addr; the device nibble is checked on the way through.
  logic [10:0] addr_sr_q;
  // Seven stored bits plus the 8th on wr_bus form the write byte.
  logic [6:0]  data_sr_q;
  logic [7:0]  out_sr_q;
  logic        slave_ready_q;
  logic        slave_valid_q;
  logic        ack_q;
  logic        s_wr_en_q;
  logic        s_rd_en_q;
  logic [11:0] s_addr_q;
  logic [7:0]  s_wr_data_q;

  logic beat_in;
  logic beat_out;
  logic dev_hit;

  assign beat_in  = master_valid & slave_ready_q;
  assign beat_out = slave_valid_q & master_ready;

  // Device nibble sits at [3:0] after 4 bits and at [4:1] after 5 bits. A
  // mismatch leaves ADDR at beat 6, so any later ADDR cycle is a match.
  always_comb begin
    dev_hit = 1'b0;
    if (cnt_q == 4'd4) begin
      dev_hit = (addr_sr_q[3:0] == DEVICE_ID);
    end else if (cnt_q == 4'd5) begin
      dev_hit = (addr_sr_q[4:1] == DEVICE_ID);
    end else if (cnt_q >= 4'd6) begin
      dev_hit = 1'b1;
    end
  end

  // During ADDR ack follows the shift register; afterwards it is held in ack_q.
  assign ack         = ack_q | ((state_q == StAddr) & dev_hit);
  assign slave_ready = slave_ready_q;
  assign slave_valid = slave_valid_q;
  assign rd_bus      = out_sr_q[7];
  assign s_addr      = s_addr_q;
  assign s_wr_data   = s_wr_data_q;
  assign s_wr_en     = s_wr_en_q;
  assign s_rd_en     = s_rd_en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      mode_q        <= 1'b0;
      addr_sr_q     <= '0;
      data_sr_q     <= '0;
      out_sr_q      <= '0;
      slave_ready_q <= 1'b1;
      slave_valid_q <= 1'b0;
      ack_q         <= 1'b0;
      s_wr_en_q     <= 1'b0;
      s_rd_en_q     <= 1'b0;
      s_addr_q      <= '0;
      s_wr_data_q   <= '0;
    end else begin
      // Strobes are single-cycle pulses unless set below.
      s_wr_en_q <= 1'b0;
      s_rd_en_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (beat_in) begin
            addr_sr_q <= {addr_sr_q[9:0], wr_bus};
            mode_q    <= mode;
            cnt_q     <= 4'd1;
            state_q   <= StAddr;
          end
        end

        StAddr: begin
          if (beat_in) begin
            addr_sr_q <= {addr_sr_q[9:0], wr_bus};
            cnt_q     <= cnt_q + 4'd1;
            if ((cnt_q == 4'd5) && !dev_hit) begin
              // 6th beat without a match: stop accepting, wait for the master.
              state_q       <= StSkip;
              slave_ready_q <= 1'b0;
              cnt_q         <= 4'd0;
            end else if (cnt_q == 4'd15) begin
              s_addr_q <= {addr_sr_q, wr_bus};
              ack_q    <= 1'b1;
              cnt_q    <= 4'd0;
              if (mode_q) begin
                state_q <= StWrData;
              end else begin
                state_q       <= StRdReq;
                slave_ready_q <= 1'b0;
                s_rd_en_q     <= 1'b1;
              end
            end
          end
        end

        StSkip: begin
          if (!master_valid) begin
            state_q       <= StIdle;
            slave_ready_q <= 1'b1;
          end
        end

        StWrData: begin
          if (beat_in) begin
            data_sr_q <= {data_sr_q[5:0], wr_bus};
            cnt_q     <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              s_wr_data_q <= {data_sr_q, wr_bus};
              s_wr_en_q   <= 1'b1;
              ack_q       <= 1'b0;
              cnt_q       <= 4'd0;
              state_q     <= StIdle;
            end
          end
        end

        StRdReq: begin
          // s_rd_en_q is high for exactly this cycle.
          state_q <= StRdWait;
        end

        StRdWait: begin
          if (cnt_q == LatLast) begin
            out_sr_q      <= s_rd_data;
            cnt_q         <= 4'd0;
            slave_valid_q <= 1'b1;
            state_q       <= StRdData;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        StRdData: begin
          if (beat_out) begin
            out_sr_q <= {out_sr_q[6:0], 1'b0};
            cnt_q    <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              slave_valid_q <= 1'b0;
              slave_ready_q <= 1'b1;
              ack_q         <= 1'b0;
              cnt_q         <= 4'd0;
              state_q       <= StIdle;
            end
          end
        end

        default: begin
          state_q       <= StIdle;
          slave_ready_q <= 1'b1;
          slave_valid_q <= 1'b0;
          ack_q         <= 1'b0;
          cnt_q         <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_port.sv
// -----------------------------------------------------------------------------
// tb_slave_port
//   Two slave_port instances: index 0 with DEVICE_ID=0, RD_LATENCY=1 and
//   index 1 with DEVICE_ID=5, RD_LATENCY=3. Each has a small memory model that
//   presents the programmed byte only in the cycle RD_LATENCY after s_rd_en.
//   A table of transactions is applied by a master model; expected write and
//   read results go into queues and are checked by a monitor as the DUT
//   produces them.
// -----------------------------------------------------------------------------
module tb_slave_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst    = 2'b11;
  logic [1:0] mode   = 2'b00;
  logic [1:0] wr_bus = 2'b00;
  logic [1:0] mvalid = 2'b00;
  logic [1:0] mready = 2'b00;
  wire  [1:0] sready;
  wire  [1:0] ack;
  wire  [1:0] rd_bus;
  wire  [1:0] svalid;
  wire  [1:0] wen;
  wire  [1:0] ren;
  wire  [11:0] saddr [2];
  wire  [7:0]  swdata [2];
  logic [7:0]  mem_val [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int Lat = (g == 0) ? 1 : 3;
    logic [3:0] vpipe = 4'b0000;
    logic [7:0] mem_data;

    slave_port #(
      .DEVICE_ID  ((g == 0) ? 4'h0 : 4'h5),
      .RD_LATENCY (Lat)
    ) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .mode         (mode[g]),
      .wr_bus       (wr_bus[g]),
      .master_valid (mvalid[g]),
      .slave_ready  (sready[g]),
      .ack          (ack[g]),
      .rd_bus       (rd_bus[g]),
      .slave_valid  (svalid[g]),
      .master_ready (mready[g]),
      .s_addr       (saddr[g]),
      .s_wr_data    (swdata[g]),
      .s_wr_en      (wen[g]),
      .s_rd_en      (ren[g]),
      .s_rd_data    (mem_data)
    );

    // Outside the valid window the memory drives the inverted byte.
    always @(posedge clk) vpipe <= {vpipe[2:0], ren[g]};
    assign mem_data = vpipe[Lat-1] ? mem_val[g] : ~mem_val[g];
  end

  typedef struct {
    int          d;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          hit;
    logic [7:0]  mr;
    bit          gap;
  } vec_t;

  typedef struct {
    int          d;
    logic [11:0] a;
    logic [7:0]  b;
  } wexp_t;

  typedef struct {
    int         d;
    logic [7:0] b;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    wen_cnt [2] = '{0, 0};
  int    ren_cnt [2] = '{0, 0};

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no event within bound, want event (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [7:0] acc [2];
    int         nb [2];
    logic       hold [2];
    logic       held_b [2];
    wexp_t      we;
    rexp_t      re;
    nb   = '{0, 0};
    hold = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst[d]) begin
          nb[d]   = 0;
          hold[d] = 1'b0;
        end else begin
          if (wen[d] === 1'b1) begin
            wen_cnt[d]++;
            if (wq.size() > 0 && wq[0].d == d) begin
              we = wq.pop_front();
              check("s_addr", 32'(saddr[d]), 32'(we.a));
              check("s_wr_data", 32'(swdata[d]), 32'(we.b));
            end else begin
              check("spurious_s_wr_en", 32'(wen[d]), 32'd0);
            end
          end
          if (ren[d] === 1'b1) ren_cnt[d]++;
          if (hold[d]) begin
            check("rd_hold_valid", 32'(svalid[d]), 32'd1);
            check("rd_hold_bit", 32'(rd_bus[d]), 32'(held_b[d]));
          end
          hold[d]   = (svalid[d] === 1'b1) && !mready[d];
          held_b[d] = rd_bus[d];
          if (svalid[d] === 1'b1 && mready[d]) begin
            acc[d] = {acc[d][6:0], rd_bus[d]};
            nb[d]++;
            if (nb[d] == 8) begin
              nb[d] = 0;
              if (rq.size() > 0 && rq[0].d == d) begin
                re = rq.pop_front();
                check("rd_byte", 32'(acc[d]), 32'(re.b));
              end else begin
                fail_bound("unexpected_rd_byte");
              end
            end
          end
        end
      end
    end
  endtask

  // Drive one wr_bus bit until it is accepted; a = ack seen in the beat cycle.
  task automatic send_bit(int d, logic b, output logic a);
    logic r;
    mvalid[d] = 1'b1;
    wr_bus[d] = b;
    a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r = sready[d];
      a = ack[d];
      @(posedge clk);
      #1;
      if (r === 1'b1) return;
    end
    fail_bound("beat_timeout");
  endtask

  task automatic check_reset(int d);
    check("rst_slave_ready", 32'(sready[d]), 32'd1);
    check("rst_ack", 32'(ack[d]), 32'd0);
    check("rst_rd_bus", 32'(rd_bus[d]), 32'd0);
    check("rst_slave_valid", 32'(svalid[d]), 32'd0);
    check("rst_s_wr_en", 32'(wen[d]), 32'd0);
    check("rst_s_rd_en", 32'(ren[d]), 32'd0);
    check("rst_s_addr", 32'(saddr[d]), 32'd0);
    check("rst_s_wr_data", 32'(swdata[d]), 32'd0);
  endtask

  task automatic run_txn(vec_t v);
    int   d;
    int   wc0;
    int   rc0;
    logic a;
    int   cyc;
    int   first;
    int   beats;
    wexp_t we;
    rexp_t re;
    d          = v.d;
    mode[d]    = v.wr;
    mem_val[d] = v.data;
    wc0        = wen_cnt[d];
    rc0        = ren_cnt[d];

    for (int k = 1; k <= 16; k++) begin
      if (v.gap && k == 9) begin
        mvalid[d] = 1'b0;
        tick();
      end
      send_bit(d, v.addr[16-k], a);
      if (k == 4) check("ack_beat4", 32'(a), 32'd0);
      if (k == 5) check("ack_beat5", 32'(a), 32'(v.hit));
      if (k == 6) check("ack_beat6", 32'(a), 32'(v.hit));
      if (k == 16) check("ack_beat16", 32'(a), 32'd1);
      if (!v.hit && k == 6) break;
    end

    if (!v.hit) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        check("skip_ready", 32'(sready[d]), 32'd0);
        check("skip_ack", 32'(ack[d]), 32'd0);
        @(posedge clk);
        #1;
      end
      mvalid[d] = 1'b0;
      tick();
      @(negedge clk);
      check("skip_exit_ready", 32'(sready[d]), 32'd1);
      tick();
      tick();
      check("skip_no_wr", 32'(wen_cnt[d] - wc0), 32'd0);
      check("skip_no_rd", 32'(ren_cnt[d] - rc0), 32'd0);
    end else if (v.wr) begin
      we.d = d;
      we.a = v.addr[11:0];
      we.b = v.data;
      wq.push_back(we);
      for (int k = 1; k <= 8; k++) begin
        if (v.gap && k == 4) begin
          mvalid[d] = 1'b0;
          tick();
        end
        send_bit(d, v.data[8-k], a);
        if (k == 1) check("ack_wr_data", 32'(a), 32'd1);
      end
      mvalid[d] = 1'b0;
      @(negedge clk);
      check("wr_strobe_latency", 32'(wen[d]), 32'd1);
      tick();
      tick();
      check("wr_strobe_count", 32'(wen_cnt[d] - wc0), 32'd1);
      check("wr_no_rd", 32'(ren_cnt[d] - rc0), 32'd0);
    end else begin
      mvalid[d] = 1'b0;
      re.d = d;
      re.b = v.data;
      rq.push_back(re);
      cyc   = 0;
      first = -1;
      beats = 0;
      for (int i = 0; i < 100 && beats < 8; i++) begin
        mready[d] = v.mr[3'(i)];
        @(negedge clk);
        cyc++;
        if (svalid[d] === 1'b1 && first < 0) first = cyc;
        if (svalid[d] === 1'b1 && mready[d]) beats++;
        @(posedge clk);
        #1;
      end
      mready[d] = 1'b0;
      if (beats < 8) fail_bound("rd_beats");
      check("rd_first_valid_cycle", 32'(first), 32'(lat_of(d) + 2));
      @(negedge clk);
      check("rd_valid_drop", 32'(svalid[d]), 32'd0);
      check("rd_idle_ready", 32'(sready[d]), 32'd1);
      tick();
      tick();
      check("rd_strobe_count", 32'(ren_cnt[d] - rc0), 32'd1);
      check("rd_no_wr", 32'(wen_cnt[d] - wc0), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tv [10];
    vec_t        post;
    logic [15:0] ra;
    logic [7:0]  rb;
    logic        a;

    tv[0] = '{0, 1'b1, 16'h0A5C, 8'h3C, 1'b1, 8'hFF, 1'b0};
    tv[1] = '{0, 1'b0, 16'h0123, 8'hC5, 1'b1, 8'hFF, 1'b0};
    tv[2] = '{0, 1'b1, 16'h7123, 8'h55, 1'b0, 8'hFF, 1'b0};
    tv[3] = '{0, 1'b0, 16'h0456, 8'h81, 1'b1, 8'hAA, 1'b0};
    tv[4] = '{0, 1'b1, 16'h0FFF, 8'h00, 1'b1, 8'hFF, 1'b1};
    tv[5] = '{0, 1'b0, 16'h0000, 8'hFF, 1'b1, 8'h6D, 1'b1};
    tv[6] = '{0, 1'b0, 16'hF000, 8'h00, 1'b0, 8'hFF, 1'b0};
    tv[7] = '{1, 1'b1, 16'h5BEE, 8'h96, 1'b1, 8'hFF, 1'b0};
    tv[8] = '{1, 1'b0, 16'h5BEE, 8'h69, 1'b1, 8'hFF, 1'b0};
    tv[9] = '{1, 1'b1, 16'h0123, 8'h11, 1'b0, 8'hFF, 1'b0};
    post  = '{0, 1'b1, 16'h0321, 8'hA7, 1'b1, 8'hFF, 1'b0};
    mem_val = '{8'h00, 8'h00};

    fork
      monitor();
    join_none

    rst = 2'b11;
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_reset(d);
    rst = 2'b00;
    tick();

    foreach (tv[i]) run_txn(tv[i]);

    // Reset at the 4th write-data beat aborts the write.
    ra = 16'h0A5C;
    rb = 8'h3C;
    mode[0] = 1'b1;
    for (int k = 1; k <= 16; k++) send_bit(0, ra[16-k], a);
    for (int k = 1; k <= 3; k++) send_bit(0, rb[8-k], a);
    mvalid[0] = 1'b1;
    wr_bus[0] = rb[4];
    rst[0]    = 1'b1;
    tick();
    @(negedge clk);
    check_reset(0);
    begin
      int wc0;
      wc0       = wen_cnt[0];
      rst[0]    = 1'b0;
      mvalid[0] = 1'b0;
      tick();
      tick();
      tick();
      check("rst_abort_no_wr", 32'(wen_cnt[0] - wc0), 32'd0);
    end
    run_txn(post);

    repeat (4) tick();
    check("wr_queue_drained", 32'(wq.size()), 32'd0);
    check("rd_queue_drained", 32'(rq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
